// File: rtl/fifo_stream_out_if.sv
// Handshake bundle between the circular FIFO read port, the stream adapter
// and the downstream decode/rename stage.
interface fifo_stream_out_if #(
  parameter type T = logic [31:0]
);
  logic fifo_empty;
  logic fifo_read_en;
  T     fifo_read_data;
  logic m_valid;
  T     m_data;
  logic m_ready;

  // Adapter side: drives the FIFO read strobe and the outgoing stream.
  modport master (
    input  fifo_empty,
    input  fifo_read_data,
    input  m_ready,
    output fifo_read_en,
    output m_valid,
    output m_data
  );

  // Environment side: FIFO plus downstream consumer.
  modport slave (
    output fifo_empty,
    output fifo_read_data,
    output m_ready,
    input  fifo_read_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_stream_out.sv
// Read-side adapter for the circular FIFO: issues credit-checked reads,
// captures the registered read data one cycle later into a 2-entry
// head/skid buffer and presents it as a bubble-free valid/ready stream.
module fifo_stream_out #(
  parameter type T = logic [31:0]
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  fifo_stream_out_if.master  bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

  occ_state_t occ_reg, occ_next;
  logic       inflight_reg, inflight_next;
  T           head_reg, head_next;
  T           skid_reg, skid_next;

  logic       pop;
  logic       ret;
  logic       read_en;
  logic [2:0] credit_used;

  // Head of the buffer is the stream output; forced quiet while in reset.
  assign bus.m_valid = !reset && (occ_reg != EMPTY);
  assign bus.m_data  = reset ? '0 : head_reg;

  assign pop = bus.m_valid && bus.m_ready;
  // Data returning this cycle is kept unless a flush discards it.
  assign ret = inflight_reg && !flush;

  // Slots already committed (buffered + in flight) after this cycle's pop.
  // pop implies occ >= 1, so this never underflows.
  assign credit_used = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign read_en     = !reset && !flush && !bus.fifo_empty && (credit_used < 3'd2);
  assign bus.fifo_read_en = read_en;

  // Next-state: buffer occupancy transitions driven by return and pop.
  always_comb begin
    occ_next      = occ_reg;
    head_next     = head_reg;
    skid_next     = skid_reg;
    inflight_next = read_en;
    case (occ_reg)
      EMPTY: begin
        if (ret) begin
          occ_next  = ONE;
          head_next = bus.fifo_read_data;
        end
      end
      ONE: begin
        if (ret && !pop) begin
          occ_next  = TWO;
          skid_next = bus.fifo_read_data;
        end else if (ret && pop) begin
          head_next = bus.fifo_read_data;
        end else if (pop) begin
          occ_next = EMPTY;
        end
      end
      TWO: begin
        // Credit check keeps returns out of this state; only drain here.
        if (pop) begin
          occ_next  = ONE;
          head_next = skid_reg;
        end
      end
      default: occ_next = EMPTY;
    endcase
    // Flush drops buffered entries; the in-flight one is dropped via ret.
    if (flush) begin
      occ_next = EMPTY;
    end
  end

  // State register with synchronous reset clearing payload as well.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_reg      <= EMPTY;
      inflight_reg <= 1'b0;
      head_reg     <= '0;
      skid_reg     <= '0;
    end else begin
      occ_reg      <= occ_next;
      inflight_reg <= inflight_next;
      head_reg     <= head_next;
      skid_reg     <= skid_next;
    end
  end

endmodule

// File: tb/tb_fifo_stream_out.sv
// Self-checking bench for fifo_stream_out: behavioural FIFO, an
// order-of-entries reference model and directed/random stimulus.
module tb_fifo_stream_out;

  logic clk;
  logic reset;
  logic flush;

  fifo_stream_out_if bus ();

  fifo_stream_out dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural FIFO contents and the expected stream (entries pushed and
  // not yet delivered or discarded), in order.
  logic [31:0] fifo_q[$];
  logic [31:0] exp_q[$];
  int          occ_m      = 0;
  bit          inflight_m = 0;
  bit          do_read    = 0;

  // Observation logs.
  int          cyc = 0;
  logic [31:0] pop_data[$];
  int          pop_cyc[$];
  int          rd_cnt = 0;
  int          first_rd_cyc = -1;
  logic        last_rd, last_mv;
  logic [31:0] last_md;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    pop_data.delete();
    pop_cyc.delete();
    rd_cnt = 0;
    first_rd_cyc = -1;
  endtask

  task automatic push(input logic [31:0] d);
    fifo_q.push_back(d);
    exp_q.push_back(d);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic drop_front(input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  // Mid-cycle observation: compare the DUT against the entry-order model.
  task automatic monitor();
    logic rd, mv, mpop, ret, exp_rd;
    logic [31:0] md;
    rd = bus.fifo_read_en;
    mv = bus.m_valid;
    md = bus.m_data;
    cyc++;
    last_rd = rd;
    last_mv = mv;
    last_md = md;
    if (reset) begin
      chk("reset_read_en", {31'd0, rd}, 32'd0);
      chk("reset_m_valid", {31'd0, mv}, 32'd0);
      chk("reset_m_data", md, 32'd0);
      drop_front(occ_m + int'(inflight_m));
      occ_m = 0;
      inflight_m = 0;
      do_read = 0;
      return;
    end
    mpop   = (occ_m != 0) && bus.m_ready;
    ret    = inflight_m && !flush;
    exp_rd = !flush && !bus.fifo_empty &&
             ((occ_m + int'(inflight_m) - int'(mpop)) < 2);
    chk("read_en", {31'd0, rd}, {31'd0, exp_rd});
    if (rd) chk("read_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
    chk("m_valid", {31'd0, mv}, {31'd0, (occ_m != 0)});
    if (occ_m != 0 && exp_q.size() > 0) chk("m_data", md, exp_q[0]);
    if (ret) chk("ret_in_two", {31'd0, (occ_m >= 2)}, 32'd0);
    if (mv && bus.m_ready) begin
      pop_data.push_back(md);
      pop_cyc.push_back(cyc);
    end
    if (mpop) begin
      drop_front(1);
      occ_m--;
    end
    if (ret) occ_m++;
    if (flush) begin
      drop_front(occ_m + int'(inflight_m));
      occ_m = 0;
    end
    if (rd) begin
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    inflight_m = rd;
    do_read    = rd;
  endtask

  // One clock cycle: observe at the falling edge, then model the FIFO's
  // registered read port just after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (do_read && fifo_q.size() > 0) bus.fifo_read_data = fifo_q.pop_front();
    bus.fifo_empty = (fifo_q.size() == 0);
  endtask

  initial begin
    logic [31:0] sent_q[$];
    logic [31:0] pop0;
    int sent;

    reset = 1'b1;
    flush = 1'b0;
    bus.m_ready = 1'b1;
    bus.fifo_empty = 1'b1;
    bus.fifo_read_data = 32'd0;

    // Reset held two cycles with FIFO preloaded 0x10..0x17.
    for (int i = 0; i < 8; i++) push(32'h10 + i);
    tick();
    tick();
    reset = 1'b0;
    clear_logs();

    // Streaming: first read right after reset, 8 entries back-to-back.
    tick();
    chk("rst_first_read", {31'd0, last_rd}, 32'd1);
    repeat (11) tick();
    chk("stream_reads", rd_cnt, 8);
    chk("stream_pops", pop_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_data.size()) begin
        chk("stream_data", pop_data[i], 32'h10 + i);
        chk("stream_cycle", pop_cyc[i], first_rd_cyc + 2 + i);
      end
    end

    // Back-pressure: only two reads while stalled, head held stable.
    bus.m_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < 6; i++) push(32'h20 + i);
    repeat (6) tick();
    chk("bp_reads", rd_cnt, 2);
    chk("bp_occ", int'(dut.occ_reg), 2);
    chk("bp_m_valid", {31'd0, last_mv}, 32'd1);
    chk("bp_m_data", last_md, 32'h20);
    bus.m_ready = 1'b1;
    tick();
    chk("bp_resume_read", {31'd0, last_rd}, 32'd1);
    repeat (10) tick();
    chk("bp_pops", pop_data.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < pop_data.size()) chk("bp_data", pop_data[i], 32'h20 + i);
    end

    // Random payloads and random ready against the order model.
    clear_logs();
    sent = 0;
    for (int c = 0; c < 20000 && (sent < 1000 || pop_data.size() < 1000); c++) begin
      if (sent < 1000 && $urandom_range(0, 3) != 0) begin
        pop0 = $urandom;
        push(pop0);
        sent_q.push_back(pop0);
        sent++;
      end
      bus.m_ready = ($urandom_range(0, 1) == 1);
      tick();
    end
    chk("rnd_count", pop_data.size(), 1000);
    for (int i = 0; i < 1000; i++) begin
      if (i < pop_data.size()) chk("rnd_data", pop_data[i], sent_q[i]);
    end

    // Flush while a read is in flight and one entry is buffered.
    bus.m_ready = 1'b0;
    tick();
    clear_logs();
    push(32'h30);
    repeat (3) tick();
    push(32'h31);
    push(32'h32);
    tick();
    chk("fl_read_t", {31'd0, last_rd}, 32'd1);
    chk("fl_occ_one", {31'd0, last_mv}, 32'd1);
    flush = 1'b1;
    tick();
    chk("fl_no_read", {31'd0, last_rd}, 32'd0);
    flush = 1'b0;
    tick();
    chk("fl_valid_gone", {31'd0, last_mv}, 32'd0);
    chk("fl_fresh_read", {31'd0, last_rd}, 32'd1);
    tick();
    chk("fl_latency_gap", {31'd0, last_mv}, 32'd0);
    tick();
    chk("fl_next_valid", {31'd0, last_mv}, 32'd1);
    chk("fl_next_data", last_md, 32'h32);
    bus.m_ready = 1'b1;
    repeat (4) tick();
    chk("fl_pops", pop_data.size(), 1);
    pop0 = (pop_data.size() > 0) ? pop_data[0] : 32'hxxxxxxxx;
    chk("fl_pop_data", pop0, 32'h32);

    // Empty/refill boundary.
    clear_logs();
    push(32'hAB);
    repeat (4) tick();
    chk("ab_pops", pop_data.size(), 1);
    pop0 = (pop_data.size() > 0) ? pop_data[0] : 32'hxxxxxxxx;
    chk("ab_data", pop0, 32'hAB);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("gap_m_valid", {31'd0, last_mv}, 32'd0);
      chk("gap_read_en", {31'd0, last_rd}, 32'd0);
    end
    clear_logs();
    push(32'hCD);
    repeat (4) tick();
    chk("cd_pops", pop_data.size(), 1);
    pop0 = (pop_data.size() > 0) ? pop_data[0] : 32'hxxxxxxxx;
    chk("cd_data", pop0, 32'hCD);
    chk("cd_latency", (pop_cyc.size() > 0) ? pop_cyc[0] - first_rd_cyc : -1, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
